rtc_mc_bus_ctrl: RTL and testbench

Front end of the Microcontroller Interface, directly upstream of the write channel and the read channel. Synchronises the asynchronous microcontroller strobes and captures address and data. Generates single-cycle write and read enables, returns read data, and drives a ready/ack handshake back to the microcontroller.

---
 rtl/rtc_mc_bus_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rtc_mc_bus_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_mc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rtc_mc_bus_ctrl
// Synchronises MCU strobes, captures address/data and issues one-cycle
// write/read enables with an ack handshake. Optional ack timeout: RTC_BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_mc_bus_ctrl #(
   parameter int ADDR_W         = 6,
   parameter int DATA_W         = 32,
   parameter int SYNC_STAGES    = 2,
   parameter int RD_LATENCY     = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_cs_n,
   input  logic              i_wr_n,
   input  logic              i_rd_n,
   input  logic [ADDR_W-1:0] i_mc_addr,
   input  logic [DATA_W-1:0] i_mc_data,
   input  logic [DATA_W-1:0] i_reg_r_bus,
   output logic              o_wr_en,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_bus_data,
   output logic [DATA_W-1:0] o_mc_rdata,
   output logic              o_mc_ack,
   output logic              o_proto_err,
   output logic              o_timeout
);

   localparam logic [2:0] c_ST_IDLE     = 3'd0;
   localparam logic [2:0] c_ST_WR_PULSE = 3'd1;
   localparam logic [2:0] c_ST_RD_PULSE = 3'd2;
   localparam logic [2:0] c_ST_RD_WAIT  = 3'd3;
   localparam logic [2:0] c_ST_ACK      = 3'd4;
   localparam logic [2:0] c_ST_RELEASE  = 3'd5;
   localparam logic [1:0] c_RD_LAST     = 2'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

   logic [SYNC_STAGES-1:0] r_cs_sync, r_wr_sync, r_rd_sync;
   logic                   w_cs_s, w_wr_s, w_rd_s;
   logic [2:0]             r_state, w_state_nxt;
   logic                   r_is_write;
   logic [1:0]             r_wait_cnt;
   logic                   w_release, w_timeout_hit;
   logic                   w_wr_en_nxt, w_rd_en_nxt, w_ack_nxt, w_err_nxt;
   logic                   w_cap_addr, w_cap_data, w_load_rdata;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cs_sync <= '1;
         r_wr_sync <= '1;
         r_rd_sync <= '1;
      end else begin
         r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
         r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], i_wr_n};
         r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], i_rd_n};
      end
   end

   assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
   assign w_wr_s    = r_wr_sync[SYNC_STAGES-1];
   assign w_rd_s    = r_rd_sync[SYNC_STAGES-1];
   // Releasing either chip select or the strobe that started the access ends it.
   assign w_release = w_cs_s | (r_is_write ? w_wr_s : w_rd_s);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= c_ST_IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= (r_state == c_ST_RD_WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (!w_cs_s) begin
               if (!w_wr_s && !w_rd_s) w_state_nxt = c_ST_RELEASE;
               else if (!w_wr_s)       w_state_nxt = c_ST_WR_PULSE;
               else if (!w_rd_s)       w_state_nxt = c_ST_RD_PULSE;
            end
         end
         c_ST_WR_PULSE: w_state_nxt = c_ST_ACK;
         c_ST_RD_PULSE: w_state_nxt = (RD_LATENCY == 0) ? c_ST_ACK : c_ST_RD_WAIT;
         c_ST_RD_WAIT:  if (r_wait_cnt == c_RD_LAST) w_state_nxt = c_ST_ACK;
         c_ST_ACK: begin
            if (w_release)          w_state_nxt = c_ST_IDLE;
            else if (w_timeout_hit) w_state_nxt = c_ST_RELEASE;
         end
         c_ST_RELEASE:  if (w_cs_s && w_wr_s && w_rd_s) w_state_nxt = c_ST_IDLE;
         default:       w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_wr_en_nxt  = (w_state_nxt == c_ST_WR_PULSE);
      w_rd_en_nxt  = (w_state_nxt == c_ST_RD_PULSE);
      w_ack_nxt    = (w_state_nxt == c_ST_ACK);
      w_err_nxt    = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_RELEASE);
      w_cap_data   = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_WR_PULSE);
      w_cap_addr   = w_cap_data || ((r_state == c_ST_IDLE) && (w_state_nxt == c_ST_RD_PULSE));
      w_load_rdata = ((r_state == c_ST_RD_PULSE) && (RD_LATENCY == 0)) ||
                     ((r_state == c_ST_RD_WAIT) && (r_wait_cnt == c_RD_LAST));
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_wr_en     <= 1'b0;
         o_rd_en     <= 1'b0;
         o_mc_ack    <= 1'b0;
         o_proto_err <= 1'b0;
         o_addr      <= '0;
         o_bus_data  <= '0;
         o_mc_rdata  <= '0;
         r_is_write  <= 1'b0;
      end else begin
         o_wr_en     <= w_wr_en_nxt;
         o_rd_en     <= w_rd_en_nxt;
         o_mc_ack    <= w_ack_nxt;
         o_proto_err <= w_err_nxt;
         if (w_cap_addr) begin
            o_addr     <= i_mc_addr;
            r_is_write <= w_cap_data;
         end
         if (w_cap_data)   o_bus_data <= i_mc_data;
         if (w_load_rdata) o_mc_rdata <= i_reg_r_bus;
      end
   end

`ifdef RTC_BUS_TIMEOUT_EN
   localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_to_cnt;
   logic       r_timeout;

   // Counter sits at zero outside ACK, so it restarts on every entry.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_to_cnt  <= (r_state == c_ST_ACK) ? r_to_cnt + 8'd1 : 8'd0;
         r_timeout <= w_timeout_hit && !w_release;
      end
   end

   assign w_timeout_hit = (r_state == c_ST_ACK) && (r_to_cnt == c_TO_LAST);
   assign o_timeout     = r_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |8'(TIMEOUT_CYCLES);
   assign w_timeout_hit    = 1'b0;
   assign o_timeout        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_mc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_mc_bus_ctrl
// Directed bench for rtc_mc_bus_ctrl with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_mc_bus_ctrl;

   localparam int SYNC = 2;
   localparam int LAT  = 1;
   localparam int TO   = 8;
   localparam int M_IDLE = 0, M_XFER = 1, M_HOLD = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
   logic [5:0]  mc_addr = '0;
   logic [31:0] mc_data = '0;
   logic [31:0] reg_r_bus = 32'hDEAD_BEEF;

   logic        o_wr_en, o_rd_en, o_mc_ack, o_proto_err, o_timeout;
   logic [5:0]  o_addr;
   logic [31:0] o_bus_data, o_mc_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int n_wr = 0, n_rd = 0, n_err = 0, n_ack = 0;

   always #5 clk = ~clk;

   rtc_mc_bus_ctrl #(
      .ADDR_W(6), .DATA_W(32), .SYNC_STAGES(SYNC), .RD_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_cs_n(cs_n), .i_wr_n(wr_n), .i_rd_n(rd_n),
      .i_mc_addr(mc_addr), .i_mc_data(mc_data), .i_reg_r_bus(reg_r_bus),
      .o_wr_en(o_wr_en), .o_rd_en(o_rd_en), .o_addr(o_addr), .o_bus_data(o_bus_data),
      .o_mc_rdata(o_mc_rdata), .o_mc_ack(o_mc_ack), .o_proto_err(o_proto_err),
      .o_timeout(o_timeout)
   );

   function automatic logic [31:0] rd_value(input logic [5:0] a);
      return (a == 6'h1A) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(a));
   endfunction

   // Read channel: data is valid only LAT (=1) cycles after the enable.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_r_bus <= 32'hDEAD_BEEF;
      else        reg_r_bus <= o_rd_en ? rd_value(o_addr) : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (o_wr_en)     n_wr++;
      if (o_rd_en)     n_rd++;
      if (o_proto_err) n_err++;
      if (o_mc_ack)    n_ack++;
   end

   // Reference model: strobes become visible SYNC edges after the pin,
   // then each access is tracked by its age in cycles since capture.
   bit          q_cs[$], q_wr[$], q_rd[$];
   bit          s_cs, s_wr, s_rd;
   int          m_mode = M_IDLE, m_age = 0, ack_age = 1;
   bit          m_write = 0;
   logic [5:0]  m_addr = '0;
   logic [31:0] m_data = '0, m_rdata = '0;
   logic        m_wr_en = 0, m_rd_en = 0, m_ack = 0, m_err = 0, m_to = 0;
   bit          to_on;

   initial begin
      to_on = 1'b0;
`ifdef RTC_BUS_TIMEOUT_EN
      to_on = 1'b1;
`endif
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_cs.delete(); q_wr.delete(); q_rd.delete();
         for (int i = 0; i < SYNC; i++) begin
            q_cs.push_back(1'b1); q_wr.push_back(1'b1); q_rd.push_back(1'b1);
         end
         m_mode = M_IDLE; m_age = 0; m_write = 0;
         m_addr = '0; m_data = '0; m_rdata = '0;
         m_wr_en = 0; m_rd_en = 0; m_ack = 0; m_err = 0; m_to = 0;
      end else begin
         s_cs = q_cs.pop_front(); q_cs.push_back(cs_n);
         s_wr = q_wr.pop_front(); q_wr.push_back(wr_n);
         s_rd = q_rd.pop_front(); q_rd.push_back(rd_n);
         m_wr_en = 0; m_rd_en = 0; m_err = 0; m_to = 0;
         case (m_mode)
            M_IDLE: if (!s_cs) begin
               if (!s_wr && !s_rd) begin
                  m_err = 1; m_mode = M_HOLD;
               end else if (!s_wr) begin
                  m_addr = mc_addr; m_data = mc_data; m_write = 1;
                  m_age = 0; m_mode = M_XFER; m_wr_en = 1; ack_age = 1;
               end else if (!s_rd) begin
                  m_addr = mc_addr; m_write = 0;
                  m_age = 0; m_mode = M_XFER; m_rd_en = 1; ack_age = 1 + LAT;
               end
            end
            M_XFER: begin
               if (m_age >= ack_age && (s_cs || (m_write ? s_wr : s_rd))) begin
                  m_mode = M_IDLE;
               end else if (to_on && (m_age - ack_age == TO - 1)) begin
                  m_mode = M_HOLD; m_to = 1;
               end else begin
                  m_age++;
                  if (!m_write && m_age == ack_age) m_rdata = rd_value(m_addr);
               end
            end
            default: if (s_cs && s_wr && s_rd) m_mode = M_IDLE;
         endcase
         m_ack = (m_mode == M_XFER) && (m_age >= ack_age);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle_compare();
      chk("cyc_wr_en",     32'(o_wr_en),     32'(m_wr_en));
      chk("cyc_rd_en",     32'(o_rd_en),     32'(m_rd_en));
      chk("cyc_ack",       32'(o_mc_ack),    32'(m_ack));
      chk("cyc_proto_err", 32'(o_proto_err), 32'(m_err));
      chk("cyc_timeout",   32'(o_timeout),   32'(m_to));
      chk("cyc_addr",      32'(o_addr),      32'(m_addr));
      chk("cyc_bus_data",  o_bus_data,       m_data);
      chk("cyc_rdata",     o_mc_rdata,       m_rdata);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         cycle_compare();
      end
   endtask

   function automatic logic get_out(input int sel);
      case (sel)
         0: return o_wr_en;
         1: return o_rd_en;
         2: return o_mc_ack;
         3: return o_proto_err;
         default: return o_timeout;
      endcase
   endfunction

   // Returns the number of cycles until the output reaches val, or maxc+1.
   task automatic wait_out(input int sel, input logic val, input int maxc, output int n);
      n = 0;
      while (n < maxc) begin
         tick(1);
         n++;
         if (get_out(sel) == val) return;
      end
      n = maxc + 1;
   endtask

   initial begin
      int n, wr0, rd0, err0, ack0;

      tick(1);
      chk("reset_ack",   32'(o_mc_ack), 0);
      chk("reset_wr_en", 32'(o_wr_en),  0);
      chk("reset_addr",  32'(o_addr),   0);
      chk("reset_rdata", o_mc_rdata,    0);
      rst_n = 1'b1;
      tick(3);

      // Write
      wr0 = n_wr;
      mc_addr = 6'h05; mc_data = 32'hA5A5_0F0F; cs_n = 0; wr_n = 0;
      wait_out(0, 1'b1, 6, n);
      chk("wr_en_latency", 32'(n), 3);
      tick(1);
      chk("wr_en_width", 32'(o_wr_en), 0);
      chk("wr_ack_rise", 32'(o_mc_ack), 1);
      chk("wr_addr", 32'(o_addr), 32'h05);
      chk("wr_data", o_bus_data, 32'hA5A5_0F0F);
      tick(4);
      chk("wr_ack_hold", 32'(o_mc_ack), 1);
      wr_n = 1;
      wait_out(2, 1'b0, 6, n);
      chk("wr_ack_fall", 32'(n), 3);
      cs_n = 1;
      tick(4);
      chk("wr_count", 32'(n_wr - wr0), 1);

      // Read
      wr0 = n_wr; rd0 = n_rd;
      mc_addr = 6'h1A; cs_n = 0; rd_n = 0;
      wait_out(2, 1'b1, 10, n);
      chk("rd_ack_latency", 32'(n), 5);
      chk("rd_rdata", o_mc_rdata, 32'h1234_5678);
      rd_n = 1; cs_n = 1;
      tick(5);
      chk("rd_count", 32'(n_rd - rd0), 1);
      chk("rd_no_wr", 32'(n_wr - wr0), 0);

      // Long strobe
      wr0 = n_wr;
      mc_addr = 6'h22; mc_data = 32'h0BAD_F00D; cs_n = 0; wr_n = 0;
      tick(50);
      wr_n = 1; cs_n = 1;
      tick(1);
      mc_data = 32'hFFFF_FFFF; mc_addr = 6'h3F;
      tick(6);
      chk("long_wr_count", 32'(n_wr - wr0), 1);
      chk("long_data_hold", o_bus_data, 32'h0BAD_F00D);
      chk("long_addr_hold", 32'(o_addr), 32'h22);

      // Illegal strobe combination
      wr0 = n_wr; rd0 = n_rd; err0 = n_err; ack0 = n_ack;
      cs_n = 0; wr_n = 0; rd_n = 0;
      tick(6);
      chk("err_count", 32'(n_err - err0), 1);
      wr_n = 1;
      tick(8);
      chk("err_hold_no_rd", 32'(n_rd - rd0), 0);
      rd_n = 1; cs_n = 1;
      tick(4);
      chk("err_no_wr", 32'(n_wr - wr0), 0);
      chk("err_no_ack", 32'(n_ack - ack0), 0);
      rd0 = n_rd;
      mc_addr = 6'h03; cs_n = 0; rd_n = 0;
      wait_out(2, 1'b1, 10, n);
      chk("post_err_rdata", o_mc_rdata, 32'hC0DE_0003);
      rd_n = 1; cs_n = 1;
      tick(5);
      chk("post_err_rd_count", 32'(n_rd - rd0), 1);

      // Reset during ACK
      mc_addr = 6'h10; mc_data = 32'h1010_1010; cs_n = 0; wr_n = 0;
      wait_out(2, 1'b1, 10, n);
      chk("rst_pre_ack", 32'(o_mc_ack), 1);
      #1 rst_n = 0;
      #1;
      chk("rst_async_ack",  32'(o_mc_ack), 0);
      chk("rst_async_addr", 32'(o_addr), 0);
      chk("rst_async_data", o_bus_data, 0);
      chk("rst_async_rdata", o_mc_rdata, 0);
      cs_n = 1; wr_n = 1;
      tick(2);
      rst_n = 1;
      tick(2);
      wr0 = n_wr;
      mc_addr = 6'h11; mc_data = 32'h1111_2222; cs_n = 0; wr_n = 0;
      wait_out(2, 1'b1, 10, n);
      chk("rst_new_ack_latency", 32'(n), 4);
      chk("rst_new_addr", 32'(o_addr), 32'h11);
      chk("rst_new_data", o_bus_data, 32'h1111_2222);
      wr_n = 1; cs_n = 1;
      tick(5);
      chk("rst_new_wr_count", 32'(n_wr - wr0), 1);

`ifdef RTC_BUS_TIMEOUT_EN
      // Ack timeout with strobes held low
      wr0 = n_wr;
      mc_addr = 6'h2C; mc_data = 32'h5555_AAAA; cs_n = 0; wr_n = 0;
      wait_out(2, 1'b1, 10, n);
      wait_out(4, 1'b1, 12, n);
      chk("to_latency", 32'(n), 8);
      chk("to_ack_drop", 32'(o_mc_ack), 0);
      tick(20);
      chk("to_single_wr", 32'(n_wr - wr0), 1);
      wr_n = 1; cs_n = 1;
      tick(5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
